// File: rtl/mem_wb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_wb_pkg
//  Description : Types and constants shared by the memory/writeback stage:
//                the execute->memwb state struct, operation codes, access
//                size constants, FSM state encoding and the misalign rule.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_wb_pkg;

    // Width of the execute->memwb struct.
    localparam int c_STATE_W = 289;

    // Memory operation carried by the instruction.
    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;

    // Writeback source. Codes 5..7 are legal on the wire but never write.
    typedef enum logic [2:0] {
        WB_NONE = 3'd0,
        WB_ALU  = 3'd1,
        WB_MEM  = 3'd2,
        WB_PC4  = 3'd3,
        WB_IMM  = 3'd4
    } wb_op_e;

    // Load funct3 encodings.
    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    // Store funct3 encodings.
    localparam logic [2:0] c_F3_SB = 3'b000;
    localparam logic [2:0] c_F3_SH = 3'b001;
    localparam logic [2:0] c_F3_SW = 3'b010;

    // Access size lives in funct3[1:0] for both loads and stores.
    localparam logic [1:0] c_SIZE_B = 2'b00;
    localparam logic [1:0] c_SIZE_H = 2'b01;

    // Stage FSM, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Execute->memwb state. Op fields are plain vectors so that
    // out-of-range codes can be carried and rejected by the stage.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [31:0] alu_result;
        logic [31:0] csr_wdata;
        logic [1:0]  mem_op;
        logic [2:0]  funct3;
        logic [2:0]  wb_op;
        logic [40:0] ctrl_spare;
    } memwb_state_t;

    // Halfwords need addr[0]=0, words need addr[1:0]=0; byte access never faults.
    function automatic logic is_misaligned(input logic [1:0] mem_op,
                                           input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic is_mem;
        is_mem = (mem_op == MEM_LOAD) || (mem_op == MEM_STORE);
        if (!is_mem)                      return 1'b0;
        if (funct3[1:0] == c_SIZE_B)      return 1'b0;
        if (funct3[1:0] == c_SIZE_H)      return addr_lo[0];
        return (addr_lo != 2'b00);
    endfunction

    // True for the writeback codes that actually produce a register write.
    function automatic logic wb_writes(input logic [2:0] wb_op);
        return (wb_op == WB_ALU) || (wb_op == WB_MEM) ||
               (wb_op == WB_PC4) || (wb_op == WB_IMM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Selects the addressed byte/halfword of a load response word
//                and sign- or zero-extends it according to funct3.
//  Revision    : 1.0  initial release
// ============================================================================
module load_align
    import mem_wb_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection and extension.
    always_comb begin
        w_byte   = i_rdata[7:0];
        w_half   = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_result = i_rdata;
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        case (i_funct3)
            c_F3_LB:  o_result = {{24{w_byte[7]}}, w_byte};
            c_F3_LBU: o_result = {24'h0, w_byte};
            c_F3_LH:  o_result = {{16{w_half[15]}}, w_half};
            c_F3_LHU: o_result = {16'h0, w_half};
            default:  o_result = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : Final pipeline stage. Holds one instruction from execute,
//                performs its data-memory access over a valid/ready request
//                and a response channel, writes the register file, and
//                exposes a forwarding/hazard view of the held instruction.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  memwb_state_t            in_state,
    output logic                    in_ready,
    output logic                    dmem_req_valid,
    input  logic                    dmem_req_ready,
    output logic [XLEN-1:0]         dmem_addr,
    output logic                    dmem_we,
    output logic [XLEN-1:0]         dmem_wdata,
    output logic [3:0]              dmem_wstrb,
    input  logic                    dmem_rsp_valid,
    input  logic [XLEN-1:0]         dmem_rdata,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [XLEN-1:0]         rf_wdata,
    output logic                    fwd_valid,
    output logic [4:0]              fwd_rd,
    output logic [XLEN-1:0]         fwd_data,
    output logic                    fwd_busy,
    output logic                    retire_valid,
    output logic [XLEN-1:0]         retire_pc,
    output logic                    misalign_err,
    output logic [RETIRE_CNT_W-1:0] retire_cnt
);

    // The datapath below is written for a 32-bit machine only.
    if (XLEN != 32) begin : g_xlen_check
        $error("mem_wb_stage: XLEN must be 32");
    end
    if ($bits(memwb_state_t) != c_STATE_W) begin : g_state_w_check
        $error("mem_wb_stage: memwb_state_t width mismatch");
    end

    state_e                  r_state;
    state_e                  w_next_state;
    memwb_state_t            r_instr;
    logic                    r_misalign;
    logic [31:0]             r_load_data;
    logic [RETIRE_CNT_W-1:0] r_retire_cnt;

    logic        w_accept;
    logic        w_in_misalign;
    logic        w_in_is_mem;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_writes;
    logic [31:0] w_load_aligned;
    logic [31:0] w_wb_data;
    logic [31:0] w_store_data;
    logic [3:0]  w_store_strb;
    logic        w_unused_fields;

    assign in_ready      = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_accept      = in_ready && in_state.valid;
    assign w_in_misalign = is_misaligned(in_state.mem_op, in_state.funct3,
                                         in_state.alu_result[1:0]);
    assign w_in_is_mem   = ((in_state.mem_op == MEM_LOAD) ||
                            (in_state.mem_op == MEM_STORE)) && !w_in_misalign;
    assign w_is_load     = (r_instr.mem_op == MEM_LOAD);
    assign w_is_store    = (r_instr.mem_op == MEM_STORE);
    assign w_writes      = wb_writes(r_instr.wb_op) && (r_instr.rd != 5'd0);

    // State register; reset drops any outstanding request immediately.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; DONE lasts one cycle and can accept back-to-back.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_next_state = w_in_is_mem ? ST_REQ : ST_DONE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_req_ready) begin
                    w_next_state = w_is_store ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmem_rsp_valid) begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Held instruction and its misalign flag, captured on accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instr    <= '0;
            r_misalign <= 1'b0;
        end else if (w_accept) begin
            r_instr    <= in_state;
            r_misalign <= w_in_misalign;
        end
    end

    load_align u_load_align (
        .i_rdata   (dmem_rdata),
        .i_addr_lo (r_instr.alu_result[1:0]),
        .i_funct3  (r_instr.funct3),
        .o_result  (w_load_aligned)
    );

    // Load data is only taken while waiting; responses elsewhere are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_load_data <= '0;
        end else if ((r_state == ST_WAIT) && dmem_rsp_valid) begin
            r_load_data <= w_load_aligned;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_retire_cnt <= '0;
        end else if (r_state == ST_DONE) begin
            r_retire_cnt <= r_retire_cnt + RETIRE_CNT_W'(1);
        end
    end

    // Store lane replication and byte strobes.
    always_comb begin
        w_store_data = r_instr.rs2_val;
        w_store_strb = 4'hF;
        case (r_instr.funct3[1:0])
            c_SIZE_B: begin
                w_store_data = {4{r_instr.rs2_val[7:0]}};
                w_store_strb = 4'b0001 << r_instr.alu_result[1:0];
            end
            c_SIZE_H: begin
                w_store_data = {2{r_instr.rs2_val[15:0]}};
                w_store_strb = 4'b0011 << r_instr.alu_result[1:0];
            end
            default: begin
                w_store_data = r_instr.rs2_val;
                w_store_strb = 4'hF;
            end
        endcase
    end

    // Writeback source select.
    always_comb begin
        w_wb_data = '0;
        case (r_instr.wb_op)
            WB_ALU:  w_wb_data = r_instr.alu_result;
            WB_MEM:  w_wb_data = r_load_data;
            WB_PC4:  w_wb_data = r_instr.pc + 32'd4;
            WB_IMM:  w_wb_data = r_instr.imm;
            default: w_wb_data = '0;
        endcase
    end

    assign dmem_req_valid = (r_state == ST_REQ);
    assign dmem_addr      = {r_instr.alu_result[31:2], 2'b00};
    assign dmem_we        = w_is_store;
    assign dmem_wdata     = w_store_data;
    assign dmem_wstrb     = w_is_store ? w_store_strb : 4'b0000;

    assign rf_we          = (r_state == ST_DONE) && w_writes && !r_misalign;
    assign rf_waddr       = r_instr.rd;
    assign rf_wdata       = w_wb_data;

    assign fwd_valid      = (r_state != ST_IDLE) && w_writes;
    assign fwd_rd         = r_instr.rd;
    assign fwd_data       = w_wb_data;
    assign fwd_busy       = ((r_state == ST_REQ) || (r_state == ST_WAIT)) && w_is_load;

    assign retire_valid   = (r_state == ST_DONE);
    assign retire_pc      = r_instr.pc;
    assign misalign_err   = (r_state == ST_DONE) && r_misalign;
    assign retire_cnt     = r_retire_cnt;

    // Struct fields carried through but not consumed by this stage.
    assign w_unused_fields = ^{r_instr.valid, r_instr.instr, r_instr.rs1,
                               r_instr.rs2, r_instr.rs1_val, r_instr.csr_wdata,
                               r_instr.ctrl_spare};

endmodule
`default_nettype wire
